// File: rtl/control_unit_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg: shared definitions for the hardwired control sequencer.
//   - opcode constants (IR[31:27])
//   - alu_op constants driven to the datapath ALU
//   - sequencer state encoding (T0..T7, HALT); the encoding doubles as t_state
//   - strobe bundle type and opcode classification helpers
// No ports (package). Optional macro used elsewhere: CU_MEM_WAIT_EN.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int IR_W  = 32;
    localparam int OP_W  = 5;
    localparam int ALU_W = 4;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    localparam logic [ALU_W-1:0] ALU_AND = 4'h0;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'h1;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'h2;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'h3;
    localparam logic [ALU_W-1:0] ALU_SHR = 4'h4;
    localparam logic [ALU_W-1:0] ALU_SHL = 4'h5;
    localparam logic [ALU_W-1:0] ALU_ROR = 4'h6;
    localparam logic [ALU_W-1:0] ALU_ROL = 4'h7;
    localparam logic [ALU_W-1:0] ALU_NEG = 4'hA;
    localparam logic [ALU_W-1:0] ALU_NOT = 4'hB;

    typedef enum logic [3:0] {
        ST_T0   = 4'd0,
        ST_T1   = 4'd1,
        ST_T2   = 4'd2,
        ST_T3   = 4'd3,
        ST_T4   = 4'd4,
        ST_T5   = 4'd5,
        ST_T6   = 4'd6,
        ST_T7   = 4'd7,
        ST_HALT = 4'hF
    } cu_state_e;

    typedef enum logic [3:0] {
        CL_RTYPE,
        CL_UNARY,
        CL_IMM,
        CL_LDI,
        CL_LD,
        CL_ST,
        CL_OUT,
        CL_NOP,
        CL_HALT,
        CL_ILLEGAL
    } cu_class_e;

    typedef struct packed {
        logic             pc_out;
        logic             pc_in;
        logic             inc_pc;
        logic             mar_in;
        logic             mdr_in;
        logic             mdr_out;
        logic             ir_in;
        logic             y_in;
        logic             z_in;
        logic             z_low_out;
        logic             c_out;
        logic             gra;
        logic             grb;
        logic             grc;
        logic             r_in;
        logic             r_out;
        logic             ba_out;
        logic             outport_in;
        logic             read;
        logic             write;
        logic [ALU_W-1:0] alu_op;
    } cu_strobes_t;

    function automatic cu_class_e op_class(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ROR, OP_ROL, OP_SHR, OP_SHL: return CL_RTYPE;
            OP_NEG, OP_NOT:                 return CL_UNARY;
            OP_ADDI, OP_ANDI, OP_ORI:       return CL_IMM;
            OP_LDI:                         return CL_LDI;
            OP_LD:                          return CL_LD;
            OP_ST:                          return CL_ST;
            OP_OUT:                         return CL_OUT;
            OP_NOP:                         return CL_NOP;
            OP_HALT:                        return CL_HALT;
            default:                        return CL_ILLEGAL;
        endcase
    endfunction

    function automatic logic [ALU_W-1:0] alu_for_op(input logic [OP_W-1:0] op);
        case (op)
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR,  OP_ORI:  return ALU_OR;
            OP_ROR:          return ALU_ROR;
            OP_ROL:          return ALU_ROL;
            OP_SHR:          return ALU_SHR;
            OP_SHL:          return ALU_SHL;
            OP_NEG:          return ALU_NEG;
            OP_NOT:          return ALU_NOT;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// -----------------------------------------------------------------------------
// control_unit_if: bundle between the control sequencer and the datapath.
//   ir            datapath -> control   current IR value
//   strobes       control  -> datapath  pc/mar/mdr/ir/y/z/c/register/port strobes
//   read, write   control  -> memory    memory strobes
//   alu_op        control  -> datapath  ALU operation
//   run           control  -> system    high unless halted
//   illegal_op    control  -> system    one-cycle pulse on undefined opcode
//   t_state       control  -> debug     current step (T0..T7 = 0..7, HALT = F)
//   mem_ready     memory   -> control   only with CU_MEM_WAIT_EN defined
// Modports: master (control unit side), slave (datapath side).
// -----------------------------------------------------------------------------
interface control_unit_if;
    import cpu_pkg::*;

    logic [IR_W-1:0]  ir;
    logic             pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in;
    logic             y_in, z_in, z_low_out, c_out;
    logic             gra, grb, grc, r_in, r_out, ba_out, outport_in;
    logic             read, write;
    logic [ALU_W-1:0] alu_op;
    logic             run;
    logic             illegal_op;
    logic [3:0]       t_state;
`ifdef CU_MEM_WAIT_EN
    logic             mem_ready;

    modport master (
        input  ir, mem_ready,
        output pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
               y_in, z_in, z_low_out, c_out,
               gra, grb, grc, r_in, r_out, ba_out, outport_in,
               read, write, alu_op, run, illegal_op, t_state
    );
    modport slave (
        output ir, mem_ready,
        input  pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
               y_in, z_in, z_low_out, c_out,
               gra, grb, grc, r_in, r_out, ba_out, outport_in,
               read, write, alu_op, run, illegal_op, t_state
    );
`else
    modport master (
        input  ir,
        output pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
               y_in, z_in, z_low_out, c_out,
               gra, grb, grc, r_in, r_out, ba_out, outport_in,
               read, write, alu_op, run, illegal_op, t_state
    );
    modport slave (
        output ir,
        input  pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in,
               y_in, z_in, z_low_out, c_out,
               gra, grb, grc, r_in, r_out, ba_out, outport_in,
               read, write, alu_op, run, illegal_op, t_state
    );
`endif

endinterface

// File: rtl/control_unit_decode.sv
// -----------------------------------------------------------------------------
// cu_decode: purely combinational step decoder.
//   state_i    in   current sequencer state
//   opcode_i   in   IR[31:27]
//   strobes_o  out  strobe bundle for this step (Moore decode)
//   next_o     out  next state assuming the step completes this cycle
//   illegal_o  out  undefined opcode seen in T3
// -----------------------------------------------------------------------------
module cu_decode
    import cpu_pkg::*;
(
    input  cu_state_e       state_i,
    input  logic [OP_W-1:0] opcode_i,
    output cu_strobes_t     strobes_o,
    output cu_state_e       next_o,
    output logic            illegal_o
);

    cu_class_e        cls;
    logic [ALU_W-1:0] op_alu;

    assign cls    = op_class(opcode_i);
    assign op_alu = alu_for_op(opcode_i);

    always_comb begin
        strobes_o = '0;
        next_o    = ST_T0;
        illegal_o = 1'b0;
        case (state_i)
            ST_T0: begin
                strobes_o.pc_out = 1'b1;
                strobes_o.mar_in = 1'b1;
                strobes_o.inc_pc = 1'b1;
                strobes_o.z_in   = 1'b1;
                strobes_o.alu_op = ALU_ADD;
                next_o           = ST_T1;
            end
            ST_T1: begin
                strobes_o.z_low_out = 1'b1;
                strobes_o.pc_in     = 1'b1;
                strobes_o.read      = 1'b1;
                strobes_o.mdr_in    = 1'b1;
                next_o              = ST_T2;
            end
            ST_T2: begin
                strobes_o.mdr_out = 1'b1;
                strobes_o.ir_in   = 1'b1;
                next_o            = ST_T3;
            end
            ST_T3: begin
                case (cls)
                    CL_RTYPE, CL_IMM: begin
                        strobes_o.grb   = 1'b1;
                        strobes_o.r_out = 1'b1;
                        strobes_o.y_in  = 1'b1;
                        next_o          = ST_T4;
                    end
                    CL_UNARY: begin
                        strobes_o.grb    = 1'b1;
                        strobes_o.r_out  = 1'b1;
                        strobes_o.alu_op = op_alu;
                        strobes_o.z_in   = 1'b1;
                        next_o           = ST_T4;
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        strobes_o.grb    = 1'b1;
                        strobes_o.ba_out = 1'b1;
                        strobes_o.y_in   = 1'b1;
                        next_o           = ST_T4;
                    end
                    CL_OUT: begin
                        strobes_o.gra        = 1'b1;
                        strobes_o.r_out      = 1'b1;
                        strobes_o.outport_in = 1'b1;
                    end
                    CL_NOP:  next_o = ST_T0;
                    CL_HALT: next_o = ST_HALT;
                    default: illegal_o = 1'b1;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CL_RTYPE: begin
                        strobes_o.grc    = 1'b1;
                        strobes_o.r_out  = 1'b1;
                        strobes_o.alu_op = op_alu;
                        strobes_o.z_in   = 1'b1;
                        next_o           = ST_T5;
                    end
                    CL_UNARY: begin
                        strobes_o.z_low_out = 1'b1;
                        strobes_o.gra       = 1'b1;
                        strobes_o.r_in      = 1'b1;
                    end
                    CL_IMM: begin
                        strobes_o.c_out  = 1'b1;
                        strobes_o.alu_op = op_alu;
                        strobes_o.z_in   = 1'b1;
                        next_o           = ST_T5;
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        // effective address / immediate = Rb-or-0 + C
                        strobes_o.c_out  = 1'b1;
                        strobes_o.alu_op = ALU_ADD;
                        strobes_o.z_in   = 1'b1;
                        next_o           = ST_T5;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CL_RTYPE, CL_IMM, CL_LDI: begin
                        strobes_o.z_low_out = 1'b1;
                        strobes_o.gra       = 1'b1;
                        strobes_o.r_in      = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        strobes_o.z_low_out = 1'b1;
                        strobes_o.mar_in    = 1'b1;
                        next_o              = ST_T6;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (cls)
                    CL_LD: begin
                        strobes_o.read   = 1'b1;
                        strobes_o.mdr_in = 1'b1;
                        next_o           = ST_T7;
                    end
                    CL_ST: begin
                        // read stays low so the MDR captures Ra from the bus
                        strobes_o.gra    = 1'b1;
                        strobes_o.r_out  = 1'b1;
                        strobes_o.mdr_in = 1'b1;
                        next_o           = ST_T7;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (cls)
                    CL_LD: begin
                        strobes_o.mdr_out = 1'b1;
                        strobes_o.gra     = 1'b1;
                        strobes_o.r_in    = 1'b1;
                    end
                    CL_ST:   strobes_o.write = 1'b1;
                    default: ;
                endcase
            end
            ST_HALT: next_o = ST_HALT;
            default: next_o = ST_T0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit: hardwired control sequencer for the datapath.
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high; forces all strobes low while high
//   bus    control_unit_if.master (ir in; strobes, alu_op, run, illegal_op,
//          t_state out; mem_ready in when CU_MEM_WAIT_EN is defined)
// Optional macro CU_MEM_WAIT_EN: fetch-read (T1), ld-T6 and st-T7 hold until
// mem_ready is sampled high.
// -----------------------------------------------------------------------------
module control_unit
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    control_unit_if.master bus
);

    cu_state_e       state_q, state_d;
    cu_state_e       dec_next;
    cu_strobes_t     dec_strb, strb;
    logic            dec_illegal;
    logic [OP_W-1:0] opcode;

    assign opcode = bus.ir[IR_W-1 -: OP_W];

    cu_decode u_decode (
        .state_i   (state_q),
        .opcode_i  (opcode),
        .strobes_o (dec_strb),
        .next_o    (dec_next),
        .illegal_o (dec_illegal)
    );

`ifdef CU_MEM_WAIT_EN
    logic mem_step;

    always_comb begin
        mem_step = (state_q == ST_T1) ||
                   (state_q == ST_T6 && op_class(opcode) == CL_LD) ||
                   (state_q == ST_T7 && op_class(opcode) == CL_ST);
        state_d  = (mem_step && !bus.mem_ready) ? state_q : dec_next;
    end
`else
    assign state_d = dec_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are gated by reset itself so an instruction aborted mid-sequence
    // drives nothing in the reset cycle, not just from the following one.
    assign strb = reset ? '0 : dec_strb;

    assign bus.pc_out     = strb.pc_out;
    assign bus.pc_in      = strb.pc_in;
    assign bus.inc_pc     = strb.inc_pc;
    assign bus.mar_in     = strb.mar_in;
    assign bus.mdr_in     = strb.mdr_in;
    assign bus.mdr_out    = strb.mdr_out;
    assign bus.ir_in      = strb.ir_in;
    assign bus.y_in       = strb.y_in;
    assign bus.z_in       = strb.z_in;
    assign bus.z_low_out  = strb.z_low_out;
    assign bus.c_out      = strb.c_out;
    assign bus.gra        = strb.gra;
    assign bus.grb        = strb.grb;
    assign bus.grc        = strb.grc;
    assign bus.r_in       = strb.r_in;
    assign bus.r_out      = strb.r_out;
    assign bus.ba_out     = strb.ba_out;
    assign bus.outport_in = strb.outport_in;
    assign bus.read       = strb.read;
    assign bus.write      = strb.write;
    assign bus.alu_op     = strb.alu_op;
    assign bus.run        = reset || (state_q != ST_HALT);
    assign bus.illegal_op = !reset && dec_illegal;
    assign bus.t_state    = state_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit: self-checking bench for control_unit.
// The reference model expands each instruction into its list of expected
// per-cycle output words straight from the step tables; the DUT is compared
// against it cycle by cycle. Inputs are driven and outputs sampled around the
// falling edge. Honours CU_MEM_WAIT_EN for the memory-wait scenario.
// -----------------------------------------------------------------------------
module tb_control_unit;

    localparam logic [19:0] PC_OUT = 20'h00001, PC_IN  = 20'h00002, INC_PC = 20'h00004,
                            MAR_IN = 20'h00008, MDR_IN = 20'h00010, MDR_OUT = 20'h00020,
                            IR_IN  = 20'h00040, Y_IN   = 20'h00080, Z_IN   = 20'h00100,
                            Z_LOW  = 20'h00200, C_OUT  = 20'h00400, GRA    = 20'h00800,
                            GRB    = 20'h01000, GRC    = 20'h02000, R_IN   = 20'h04000,
                            R_OUT  = 20'h08000, BA_OUT = 20'h10000, OUTP   = 20'h20000,
                            READ   = 20'h40000, WRITE  = 20'h80000;
    localparam logic [31:0] RUN_B = 32'h1000_0000;
    localparam logic [31:0] ILL_B = 32'h2000_0000;
    localparam logic [31:0] T_MASK = 32'h0F00_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [31:0] exp_q[$];

    control_unit_if cu_if ();

    control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cu_if.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs();
        logic [19:0] s;
        s = {cu_if.write, cu_if.read, cu_if.outport_in, cu_if.ba_out, cu_if.r_out,
             cu_if.r_in, cu_if.grc, cu_if.grb, cu_if.gra, cu_if.c_out, cu_if.z_low_out,
             cu_if.z_in, cu_if.y_in, cu_if.ir_in, cu_if.mdr_out, cu_if.mdr_in,
             cu_if.mar_in, cu_if.inc_pc, cu_if.pc_in, cu_if.pc_out};
        return {2'b00, cu_if.illegal_op, cu_if.run, cu_if.t_state, cu_if.alu_op, s};
    endfunction

    function automatic logic [31:0] stp(input logic [3:0] t, input logic [19:0] s,
                                        input logic [3:0] alu);
        return {4'b0001, t, alu, s};
    endfunction

    function automatic logic [3:0] ref_alu(input logic [4:0] op);
        case (op)
            5'd3, 5'd12: return 4'h2;
            5'd4:        return 4'h3;
            5'd5, 5'd13: return 4'h0;
            5'd6, 5'd14: return 4'h1;
            5'd7:        return 4'h6;
            5'd8:        return 4'h7;
            5'd9:        return 4'h4;
            5'd11:       return 4'h5;
            5'd17:       return 4'hA;
            5'd18:       return 4'hB;
            default:     return 4'h2;
        endcase
    endfunction

    task automatic build_expected(input logic [31:0] instr);
        logic [4:0] op;
        logic [3:0] a;
        op = instr[31:27];
        a  = ref_alu(op);
        exp_q.delete();
        exp_q.push_back(stp(0, PC_OUT | MAR_IN | INC_PC | Z_IN, 4'h2));
        exp_q.push_back(stp(1, Z_LOW | PC_IN | READ | MDR_IN, 0));
        exp_q.push_back(stp(2, MDR_OUT | IR_IN, 0));
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd11: begin
                exp_q.push_back(stp(3, GRB | R_OUT | Y_IN, 0));
                exp_q.push_back(stp(4, GRC | R_OUT | Z_IN, a));
                exp_q.push_back(stp(5, Z_LOW | GRA | R_IN, 0));
            end
            5'd17, 5'd18: begin
                exp_q.push_back(stp(3, GRB | R_OUT | Z_IN, a));
                exp_q.push_back(stp(4, Z_LOW | GRA | R_IN, 0));
            end
            5'd12, 5'd13, 5'd14: begin
                exp_q.push_back(stp(3, GRB | R_OUT | Y_IN, 0));
                exp_q.push_back(stp(4, C_OUT | Z_IN, a));
                exp_q.push_back(stp(5, Z_LOW | GRA | R_IN, 0));
            end
            5'd0, 5'd1, 5'd2: begin
                exp_q.push_back(stp(3, GRB | BA_OUT | Y_IN, 0));
                exp_q.push_back(stp(4, C_OUT | Z_IN, 4'h2));
                if (op == 5'd1) begin
                    exp_q.push_back(stp(5, Z_LOW | GRA | R_IN, 0));
                end else begin
                    exp_q.push_back(stp(5, Z_LOW | MAR_IN, 0));
                    if (op == 5'd0) begin
                        exp_q.push_back(stp(6, READ | MDR_IN, 0));
                        exp_q.push_back(stp(7, MDR_OUT | GRA | R_IN, 0));
                    end else begin
                        exp_q.push_back(stp(6, GRA | R_OUT | MDR_IN, 0));
                        exp_q.push_back(stp(7, WRITE, 0));
                    end
                end
            end
            5'd23:        exp_q.push_back(stp(3, GRA | R_OUT | OUTP, 0));
            5'd26, 5'd27: exp_q.push_back(stp(3, 0, 0));
            default:      exp_q.push_back(stp(3, 0, 0) | ILL_B);
        endcase
    endtask

    // Called at a falling edge with the DUT in T0; checks up to 'limit' steps.
    task automatic run_instr(input logic [31:0] instr, input string name, input int limit);
        logic [31:0] got;
        build_expected(instr);
        cu_if.ir = instr;
        for (int i = 0; i < exp_q.size() && i < limit; i++) begin
            #1;
            got = obs();
            total++;
            if (got !== exp_q[i]) begin
                bad++;
                $display("FAIL %s step %0d ir=%h got=%h want=%h", name, i, instr, got, exp_q[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [31:0] got;
        #1;
        got = obs() & ~T_MASK;
        total++;
        if (got !== RUN_B) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, RUN_B);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cu_if.ir = '0;
        @(negedge clk);
        check_reset_outputs("reset_c0");
        @(negedge clk);
        check_reset_outputs("reset_c1");
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_instr(32'h0880_0085, "ldi", 100);
        run_instr(32'h1891_8000, "add", 100);
        run_instr(32'h1080_0000, "st", 100);
        run_instr(32'h0000_0000, "ld", 100);
        run_instr(32'h5000_0000, "illegal", 100);
        run_instr(32'hD000_0000, "nop", 100);
    endtask

    task automatic test_back_to_back();
        logic [4:0] op;
        for (int n = 0; n < 60; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            run_instr({op, 27'($urandom)}, "random", 100);
        end
    endtask

    task automatic test_reset_mid();
        run_instr(32'h0000_0000, "ld_abort", 5);
        reset = 1'b1;
        check_reset_outputs("abort_t5");
        @(negedge clk);
        check_reset_outputs("abort_next");
        reset = 1'b0;
        run_instr(32'h2000_0000, "after_abort", 100);
    endtask

    task automatic test_halt();
        logic [31:0] got;
        run_instr(32'hD800_0000, "halt_fetch", 100);
        for (int c = 0; c < 22; c++) begin
            #1;
            got = obs();
            total++;
            if (got !== 32'h0F00_0000) begin
                bad++;
                $display("FAIL halt cycle %0d got=%h want=%h", c, got, 32'h0F00_0000);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("halt_reset");
        reset = 1'b0;
        run_instr(32'hD000_0000, "after_halt", 100);
    endtask

`ifdef CU_MEM_WAIT_EN
    task automatic test_mem_wait();
        logic [31:0] got;
        logic [31:0] t1;
        t1 = stp(1, Z_LOW | PC_IN | READ | MDR_IN, 0);
        run_instr(32'hD000_0000, "wait_t0", 1);
        cu_if.mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) cu_if.mem_ready = 1'b1;
            #1;
            got = obs();
            total++;
            if (got !== t1) begin
                bad++;
                $display("FAIL mem_wait_t1 cycle %0d got=%h want=%h", c, got, t1);
            end
            @(negedge clk);
        end
        #1;
        got = obs();
        total++;
        if (got !== stp(2, MDR_OUT | IR_IN, 0)) begin
            bad++;
            $display("FAIL mem_wait_t2 got=%h want=%h", got, stp(2, MDR_OUT | IR_IN, 0));
        end
        @(negedge clk);
        @(negedge clk);
        run_instr(32'hD000_0000, "after_wait", 100);
    endtask
`endif

    initial begin
`ifdef CU_MEM_WAIT_EN
        cu_if.mem_ready = 1'b1;
`endif
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_halt();
`ifdef CU_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
